// File: rtl/sort_node_delay.sv
// rtl/sort_node_delay.sv - one sift-down stage of a pipelined unsigned min-heap
// Reads both children of the refilled slot, keeps the minimum here and pushes the displaced token down.
module sort_node_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter int LEAF       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH:0]   in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH:0]   lm_addr,
    output logic                  lm_we,
    output logic [DATA_WIDTH-1:0] lm_din,
    input  logic [DATA_WIDTH-1:0] lm_dout,
    output logic [ADDR_WIDTH:0]   rm_addr,
    output logic                  rm_we,
    output logic [DATA_WIDTH-1:0] rm_din,
    input  logic [DATA_WIDTH-1:0] rm_dout,
    output logic [DATA_WIDTH-1:0] nl_din,
    output logic [ADDR_WIDTH-1:0] nl_addr,
    output logic                  nl_we,
    output logic                  nl_branch,
    output logic                  out_valid,
    output logic [ADDR_WIDTH+1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CMP  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    if (LEVEL < 0) begin : g_level_check
        $error("sort_node_delay: LEVEL must be non-negative");
    end

    localparam logic IS_LEAF = (LEAF != 0);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH:0]   r_tok_addr;
    logic [DATA_WIDTH-1:0] r_tok_data;
    logic                  w_sel;
    logic [DATA_WIDTH-1:0] w_cmin;
    logic                  w_emit;

    assign lm_we  = 1'b0;
    assign rm_we  = 1'b0;
    assign lm_din = '0;
    assign rm_din = '0;

    // Left wins ties, so the right child is chosen only when strictly smaller.
    assign w_sel  = (rm_dout < lm_dout);
    assign w_cmin = w_sel ? rm_dout : lm_dout;
    assign w_emit = !IS_LEAF && (r_tok_data > w_cmin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tok_addr <= '0;
            r_tok_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && in_valid) begin
                r_tok_addr <= in_addr;
                r_tok_data <= in_data;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        lm_addr   = '0;
        rm_addr   = '0;
        nl_din    = '0;
        nl_addr   = '0;
        nl_we     = 1'b0;
        nl_branch = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                if (!IS_LEAF) begin
                    lm_addr = r_tok_addr;
                    rm_addr = r_tok_addr;
                end
                w_next = S_CMP;
            end
            S_CMP: begin
                nl_we     = 1'b1;
                nl_addr   = r_tok_addr[ADDR_WIDTH:1];
                nl_branch = r_tok_addr[0];
                nl_din    = w_emit ? w_cmin : r_tok_data;
                if (w_emit) begin
                    out_valid = 1'b1;
                    out_addr  = {r_tok_addr, w_sel};
                    out_data  = r_tok_data;
                end
                w_next = S_GAP;
            end
            S_GAP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // A reset landing in CMP must suppress that cycle's write and token.
        if (rst) begin
            w_next    = S_IDLE;
            in_ready  = 1'b0;
            lm_addr   = '0;
            rm_addr   = '0;
            nl_din    = '0;
            nl_addr   = '0;
            nl_we     = 1'b0;
            nl_branch = 1'b0;
            out_valid = 1'b0;
            out_addr  = '0;
            out_data  = '0;
        end
    end

endmodule
